// File: rtl/mem_responder.sv
// mem_responder
//   Memory-side responder for the 16-bit CPU. Accepts one fetch/load/store
//   request at a time and answers with a single-cycle response pulse one
//   cycle after acceptance. Requests are served from an internal synchronous
//   word RAM or, when MEM_RESPONDER_MMIO_EN is defined, from a small MMIO
//   register bank (LEDR, SW, 32-bit cycle counter with hi-half snapshot).
//
//   Build option:
//     MEM_RESPONDER_MMIO_EN  compile in the MMIO window at MMIO_BASE, the
//                            ledr register, the cycle counter and the
//                            fetch-from-MMIO error detection.
//
//   Ports:
//     clk         rising-edge clock
//     reset       asynchronous, active-low reset
//     req_valid   request present
//     req_ready   responder can accept this cycle
//     req_we      1 = store, 0 = read
//     req_sel     0 = instruction fetch, 1 = data access
//     req_addr    byte address
//     req_wdata   store data
//     resp_valid  one-cycle response pulse
//     resp_rdata  read data (0 for stores), held until the next response
//     resp_sel    echo of req_sel for the response
//     err         sticky error flag (misalignment, MMIO fetch)
//     sw          switch inputs (MMIO SW register)
//     ledr        LED register (MMIO LEDR register)
module mem_responder #(
  parameter int              ADDR_W    = 16,
  parameter int              DEPTH     = 4096,
  parameter logic [ADDR_W-1:0] MMIO_BASE = 16'hF000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic              req_sel,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [15:0]       req_wdata,
  output logic              resp_valid,
  output logic [15:0]       resp_rdata,
  output logic              resp_sel,
  output logic              err,
  input  logic [9:0]        sw,
  output logic [9:0]        ledr
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  // Source of the data presented on resp_rdata during/after a response.
  typedef enum logic [1:0] {
    SRC_ZERO = 2'd0,
    SRC_RAM  = 2'd1,
    SRC_MMIO = 2'd2
  } src_t;

  state_t state_q, state_d;
  src_t   src_q, src_d;
  logic   resp_sel_q, resp_sel_d;
  logic   err_q, err_d;

  logic             ram_we;
  logic             ram_re;
  logic [IDX_W-1:0] ram_idx;
  logic [15:0]      ram_rdata_q;
  logic [15:0]      mem [DEPTH];

  logic in_mmio;

  // Word index; byte-address bit 0 is ignored and upper bits wrap modulo DEPTH.
  assign ram_idx = req_addr[IDX_W:1];

`ifdef MEM_RESPONDER_MMIO_EN
  logic [9:0]        ledr_q, ledr_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [15:0]       cnt_hi_q, cnt_hi_d;
  logic [15:0]       mmio_rdata_q, mmio_rdata_d;
  logic [ADDR_W-1:0] mmio_off;
  logic [1:0]        mmio_reg;
  logic              mmio_mapped;

  // The window runs from MMIO_BASE to the top of the address space; only the
  // first four words hold registers, the rest read 0 and ignore writes.
  assign in_mmio     = (req_addr >= MMIO_BASE);
  assign mmio_off    = req_addr - MMIO_BASE;
  assign mmio_reg    = mmio_off[2:1];
  assign mmio_mapped = (mmio_off[ADDR_W-1:3] == '0);
  assign ledr        = ledr_q;

  logic unused_bits;
  assign unused_bits = ^{req_addr, mmio_off[0]};
`else
  assign in_mmio = 1'b0;
  assign ledr    = '0;

  logic unused_bits;
  assign unused_bits = ^{req_addr, sw};
`endif

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_sel   = resp_sel_q;
  assign err        = err_q;

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    resp_sel_d = resp_sel_q;
    err_d      = err_q;
    ram_we     = 1'b0;
    ram_re     = 1'b0;
`ifdef MEM_RESPONDER_MMIO_EN
    ledr_d       = ledr_q;
    cnt_d        = cnt_q + 32'd1;
    cnt_hi_d     = cnt_hi_q;
    mmio_rdata_d = mmio_rdata_q;
`endif

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d    = RESP;
          resp_sel_d = req_sel;
          if (req_addr[0]) begin
            err_d = 1'b1;
          end
          if (in_mmio) begin
`ifdef MEM_RESPONDER_MMIO_EN
            src_d = SRC_ZERO;
            if (!req_sel) begin
              // Executing from the register bank is an error; no side effects.
              err_d = 1'b1;
            end else if (req_we) begin
              if (mmio_mapped && (mmio_reg == 2'd0)) begin
                ledr_d = req_wdata[9:0];
              end
            end else begin
              src_d        = SRC_MMIO;
              mmio_rdata_d = 16'h0000;
              if (mmio_mapped) begin
                case (mmio_reg)
                  2'd0: mmio_rdata_d = {6'b0, ledr_q};
                  2'd1: mmio_rdata_d = {6'b0, sw};
                  2'd2: begin
                    // Snapshot the high half from the same counter value so
                    // a LO-then-HI read pair is coherent.
                    mmio_rdata_d = cnt_q[15:0];
                    cnt_hi_d     = cnt_q[31:16];
                  end
                  default: mmio_rdata_d = cnt_hi_q;
                endcase
              end
            end
`endif
          end else if (req_we) begin
            ram_we = 1'b1;
            src_d  = SRC_ZERO;
          end else begin
            ram_re = 1'b1;
            src_d  = SRC_RAM;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    resp_rdata = 16'h0000;
    case (src_q)
      SRC_RAM:  resp_rdata = ram_rdata_q;
`ifdef MEM_RESPONDER_MMIO_EN
      SRC_MMIO: resp_rdata = mmio_rdata_q;
`endif
      default:  resp_rdata = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      src_q      <= SRC_ZERO;
      resp_sel_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      resp_sel_q <= resp_sel_d;
      err_q      <= err_d;
    end
  end

`ifdef MEM_RESPONDER_MMIO_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ledr_q       <= '0;
      cnt_q        <= '0;
      cnt_hi_q     <= '0;
      mmio_rdata_q <= '0;
    end else begin
      ledr_q       <= ledr_d;
      cnt_q        <= cnt_d;
      cnt_hi_q     <= cnt_hi_d;
      mmio_rdata_q <= mmio_rdata_d;
    end
  end
`endif

  // Synchronous RAM, neither initialised nor reset; a store accepted before
  // a reset stays committed.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[ram_idx] <= req_wdata;
    end
    if (ram_re) begin
      ram_rdata_q <= mem[ram_idx];
    end
  end

endmodule
